// File: rtl/ps2_pkg.sv
// Shared PS/2 constants, frame state encoding and game key codes.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ps2_pkg;

    // Prefix bytes sent ahead of break and extended scan codes.
    localparam logic [7:0] PS2_BREAK = 8'hF0;
    localparam logic [7:0] PS2_EXT   = 8'hE0;

    // Frame state encoding.
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DATA   = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;
    localparam logic [1:0] ST_STOP   = 2'd3;

    // Snake game steering keys (set 2 make codes).
    localparam logic [7:0] KEY_I = 8'h43;
    localparam logic [7:0] KEY_K = 8'h42;
    localparam logic [7:0] KEY_J = 8'h3B;
    localparam logic [7:0] KEY_L = 8'h4B;

    // Odd parity: data plus parity bit must contain an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Synchronizes one raw PS/2 pin and only lets the level change after FILTER_LEN stable samples.
// Latency: 2 sync cycles + FILTER_LEN cycles from pin edge to o_level/o_fall change.
// Backpressure: none; o_fall is a free-running one-cycle pulse.
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_pin,
    output logic o_level,
    output logic o_fall
);

    localparam int CW = $clog2(FILTER_LEN + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

    logic          r_sync0;
    logic          r_sync1;
    logic          r_level;
    logic          r_fall;
    logic [CW-1:0] r_cnt;

    // Two-flop synchronizer; idle PS/2 lines are pulled high.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sync0 <= 1'b1;
            r_sync1 <= 1'b1;
        end else begin
            r_sync0 <= i_pin;
            r_sync1 <= r_sync0;
        end
    end

    // Stability filter: a differing sample must persist FILTER_LEN cycles to be taken.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_level <= 1'b1;
            r_fall  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_fall <= 1'b0;
            if (r_sync1 != r_level) begin
                if (r_cnt == CNT_LAST) begin
                    r_level <= r_sync1;
                    r_fall  <= r_level & ~r_sync1;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign o_level = r_level;
    assign o_fall  = r_fall;

endmodule

// File: rtl/ps2_scan_code_receiver.sv
// Deserializes PS/2 device frames and decodes E0/F0 prefixes into held make/break codes.
// Latency: outputs registered, updating the cycle after the stop-bit falling edge.
// Backpressure: none; consumer samples ps2_data_out as a level, pulses are single-cycle.
module ps2_scan_code_receiver
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] ps2_data_out,
    output logic       extended,
    output logic       make_valid,
    output logic       break_valid,
    output logic [7:0] break_code,
    output logic       frame_error
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_CYCLES);

    logic w_fall;
    logic w_clk_level_unused;
    logic w_data;
    logic w_data_fall_unused;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
        .i_clk   (clk),
        .i_reset (reset),
        .i_pin   (ps2_clk),
        .o_level (w_clk_level_unused),
        .o_fall  (w_fall)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filt (
        .i_clk   (clk),
        .i_reset (reset),
        .i_pin   (ps2_data),
        .o_level (w_data),
        .o_fall  (w_data_fall_unused)
    );

    logic [1:0]    r_state;
    logic [2:0]    r_bit_cnt;
    logic [7:0]    r_shift;
    logic          r_par_ok;
    logic [TW-1:0] r_to_cnt;
    logic          r_ext_pend;
    logic          r_brk_pend;
    logic [7:0]    r_data_out;
    logic          r_extended;
    logic          r_make_vld;
    logic          r_break_vld;
    logic [7:0]    r_break_code;
    logic          r_frame_err;

    logic w_timeout;
    logic w_stop_done;
    logic w_byte_ok;
    logic w_err;

    // A falling edge always wins over a timeout in the same cycle, since it restarts the counter.
    assign w_timeout   = !w_fall && (r_state != ST_IDLE) && (r_to_cnt == TO_MAX);
    assign w_stop_done = w_fall && (r_state == ST_STOP);
    assign w_byte_ok   = w_stop_done && w_data && r_par_ok;
    assign w_err       = (w_stop_done && !(w_data && r_par_ok)) || w_timeout;

    // Frame state machine and saturating inactivity counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_par_ok  <= 1'b0;
            r_to_cnt  <= '0;
        end else begin
            if (w_fall) begin
                r_to_cnt <= '0;
            end else if (r_to_cnt != TO_MAX) begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end

            if (w_fall) begin
                case (r_state)
                    ST_IDLE: begin
                        if (!w_data) begin
                            r_state   <= ST_DATA;
                            r_bit_cnt <= '0;
                        end
                    end
                    ST_DATA: begin
                        r_shift   <= {w_data, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                        if (r_bit_cnt == 3'd7) begin
                            r_state <= ST_PARITY;
                        end
                    end
                    ST_PARITY: begin
                        r_par_ok <= odd_parity_ok(r_shift, w_data);
                        r_state  <= ST_STOP;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end else if (w_timeout) begin
                r_state <= ST_IDLE;
            end
        end
    end

    // Prefix decoder: only make codes update the held output byte.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ext_pend   <= 1'b0;
            r_brk_pend   <= 1'b0;
            r_data_out   <= 8'h00;
            r_extended   <= 1'b0;
            r_make_vld   <= 1'b0;
            r_break_vld  <= 1'b0;
            r_break_code <= 8'h00;
            r_frame_err  <= 1'b0;
        end else begin
            r_make_vld  <= 1'b0;
            r_break_vld <= 1'b0;
            r_frame_err <= 1'b0;
            if (w_err) begin
                r_frame_err <= 1'b1;
                r_ext_pend  <= 1'b0;
                r_brk_pend  <= 1'b0;
            end else if (w_byte_ok) begin
                if (r_shift == PS2_EXT) begin
                    r_ext_pend <= 1'b1;
                end else if (r_shift == PS2_BREAK) begin
                    r_brk_pend <= 1'b1;
                end else if (r_brk_pend) begin
                    r_break_code <= r_shift;
                    r_break_vld  <= 1'b1;
                    r_ext_pend   <= 1'b0;
                    r_brk_pend   <= 1'b0;
                end else begin
                    r_data_out <= r_shift;
                    r_extended <= r_ext_pend;
                    r_make_vld <= 1'b1;
                    r_ext_pend <= 1'b0;
                    r_brk_pend <= 1'b0;
                end
            end
        end
    end

    assign ps2_data_out = r_data_out;
    assign extended     = r_extended;
    assign make_valid   = r_make_vld;
    assign break_valid  = r_break_vld;
    assign break_code   = r_break_code;
    assign frame_error  = r_frame_err;

endmodule

// File: tb/tb_ps2_scan_code_receiver.sv
// Directed bench for the PS/2 scan code receiver with scaled filter and timeout parameters.
// Latency: frames are bit-banged at 100 clk per PS/2 bit.
// Backpressure: none.
module tb_ps2_scan_code_receiver;

    localparam int FILT = 4;
    localparam int TO   = 2000;
    localparam int HALF = 50;
    localparam int GAP  = 100;

    logic       clk;
    logic       reset;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] ps2_data_out;
    logic       extended;
    logic       make_valid;
    logic       break_valid;
    logic [7:0] break_code;
    logic       frame_error;

    int n_checks = 0;
    int n_errors = 0;
    int n_make   = 0;
    int n_brk    = 0;
    int n_err    = 0;
    int n_overlap = 0;
    int m0, b0, e0;

    ps2_scan_code_receiver #(.FILTER_LEN(FILT), .TIMEOUT_CYCLES(TO)) dut (
        .clk          (clk),
        .reset        (reset),
        .ps2_clk      (ps2_clk),
        .ps2_data     (ps2_data),
        .ps2_data_out (ps2_data_out),
        .extended     (extended),
        .make_valid   (make_valid),
        .break_valid  (break_valid),
        .break_code   (break_code),
        .frame_error  (frame_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count high cycles of each pulse output, and cycles with more than one pulse high.
    always @(negedge clk) begin
        if (make_valid === 1'b1)  n_make++;
        if (break_valid === 1'b1) n_brk++;
        if (frame_error === 1'b1) n_err++;
        if ((32'(make_valid) + 32'(break_valid) + 32'(frame_error)) > 1) n_overlap++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Bit-bang the first nbits of an 11-bit frame; flip inverts the odd parity bit.
    task automatic send_frame(input logic [7:0] d, input logic flip, input int nbits);
        logic [10:0] f;
        f = {1'b1, (~^d) ^ flip, d, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = f[i];
            repeat (HALF) @(posedge clk);
            ps2_clk = 1'b0;
            repeat (HALF) @(posedge clk);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        repeat (GAP) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic snap();
        m0 = n_make;
        b0 = n_brk;
        e0 = n_err;
    endtask

    initial begin
        reset    = 1'b1;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check_eq("rst_data_out", ps2_data_out, 8'h00);
        check_eq("rst_break_code", break_code, 8'h00);
        check_eq("rst_flags", {extended, make_valid, break_valid, frame_error}, 4'b0000);
        reset = 1'b0;
        repeat (20) @(posedge clk);

        // Plain make 0x43
        snap();
        send_frame(8'h43, 1'b0, 11);
        check_eq("make43_pulses", n_make - m0, 1);
        check_eq("make43_data", ps2_data_out, 8'h43);
        check_eq("make43_ext", extended, 1'b0);

        // Break sequence F0 43
        snap();
        send_frame(8'hF0, 1'b0, 11);
        send_frame(8'h43, 1'b0, 11);
        check_eq("brk43_pulses", n_brk - b0, 1);
        check_eq("brk43_code", break_code, 8'h43);
        check_eq("brk43_data_held", ps2_data_out, 8'h43);
        check_eq("brk43_no_make", n_make - m0, 0);

        // Extended make E0 75, then plain 4B
        snap();
        send_frame(8'hE0, 1'b0, 11);
        send_frame(8'h75, 1'b0, 11);
        check_eq("ext75_pulses", n_make - m0, 1);
        check_eq("ext75_data", ps2_data_out, 8'h75);
        check_eq("ext75_ext", extended, 1'b1);
        send_frame(8'h4B, 1'b0, 11);
        check_eq("plain4b_data", ps2_data_out, 8'h4B);
        check_eq("plain4b_ext", extended, 1'b0);

        // Bad parity on 0x42, then good 0x42
        snap();
        send_frame(8'h42, 1'b1, 11);
        check_eq("par_err_pulses", n_err - e0, 1);
        check_eq("par_err_data_held", ps2_data_out, 8'h4B);
        check_eq("par_err_no_make", n_make - m0, 0);
        send_frame(8'h42, 1'b0, 11);
        check_eq("good42_data", ps2_data_out, 8'h42);
        check_eq("good42_pulses", n_make - m0, 1);

        // Typematic repeat of 0x42
        snap();
        send_frame(8'h42, 1'b0, 11);
        check_eq("repeat42_pulses", n_make - m0, 1);
        check_eq("repeat42_data", ps2_data_out, 8'h42);

        // Error after F0 must clear the pending break
        snap();
        send_frame(8'hF0, 1'b0, 11);
        send_frame(8'h3B, 1'b1, 11);
        send_frame(8'h4B, 1'b0, 11);
        check_eq("clr_pend_err", n_err - e0, 1);
        check_eq("clr_pend_no_brk", n_brk - b0, 0);
        check_eq("clr_pend_make", ps2_data_out, 8'h4B);

        // Partial frame then timeout, then good 0x3B
        snap();
        send_frame(8'h3B, 1'b0, 5);
        repeat (TO + 500) @(posedge clk);
        @(negedge clk);
        check_eq("timeout_pulses", n_err - e0, 1);
        check_eq("timeout_no_make", n_make - m0, 0);
        send_frame(8'h3B, 1'b0, 11);
        check_eq("after_to_data", ps2_data_out, 8'h3B);
        check_eq("after_to_pulses", n_make - m0, 1);

        // Reset during bit 5 of a frame
        snap();
        send_frame(8'h4B, 1'b0, 7);
        reset = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check_eq("midrst_data", ps2_data_out, 8'h00);
        check_eq("midrst_flags", {extended, make_valid, break_valid, frame_error}, 4'b0000);
        reset = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        check_eq("midrst_no_pulse", (n_make - m0) + (n_brk - b0) + (n_err - e0), 0);
        send_frame(8'h4B, 1'b0, 11);
        check_eq("post_rst_data", ps2_data_out, 8'h4B);
        check_eq("post_rst_ext", extended, 1'b0);
        check_eq("post_rst_pulses", n_make - m0, 1);
        check_eq("post_rst_no_err", n_err - e0, 0);

        check_eq("pulse_overlap", n_overlap, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
